video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 24, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 136, hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 160, horizontal back porch in clocks; H_TOTAL = sum of the four H values (1344).
REQ-005 SHALL have parameters V_ACTIVE 768, V_FP 3, V_SYNC 6, V_BP 29, in lines; V_TOTAL = sum of the four (806).
REQ-006 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-007 SHALL have parameter LOCK_WAIT, default 1024, clocks of continuous lock required before timing starts.
REQ-008 clk  input  1  pixel clock, 65 MHz from the video PLL output 0; all logic on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 pll_locked  input  1  PLL lock indication, asynchronous to clk.
REQ-011 enable  input  1  synchronous run request; low forces IDLE.
REQ-012 hsync, vsync  output  1 each  sync pulses at SYNC_POL level when asserted.
REQ-013 de  output  1  data enable, high during active pixels.
REQ-014 x  output  11  active pixel column; y  output  10  active line.
REQ-015 line_start, frame_start  output  1 each  single-cycle pulses.
REQ-016 running  output  1  high while in RUN state.

Function
REQ-017 pll_locked SHALL pass through a 2-flop synchronizer; lock_s denotes the synchronized value.
REQ-018 FSM states IDLE, WAIT_LOCK, RUN; IDLE->WAIT_LOCK when enable=1 and lock_s=1.
REQ-019 WAIT_LOCK SHALL count consecutive lock_s=1 clocks; at count LOCK_WAIT-1, go to RUN; lock_s=0 or enable=0 SHALL return to IDLE and clear the count.
REQ-020 RUN->IDLE on the first clock with lock_s=0 or enable=0; no completion of the current frame.
REQ-021 h_cnt, v_cnt SHALL be 0 on the first RUN cycle.
REQ-022 In RUN, h_cnt SHALL increment each clock and wrap from H_TOTAL-1 to 0; v_cnt SHALL increment on each h wrap and wrap from V_TOTAL-1 to 0 when both wrap together.
REQ-023 All outputs SHALL be registered, exactly one clock behind the counter values they decode.
REQ-024 de = 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-025 hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line, including blanking lines.
REQ-026 vsync asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, changing on the h_cnt=0 boundary.
REQ-027 x = h_cnt and y = v_cnt when de=1; x and y SHALL be 0 when de=0.
REQ-028 line_start = 1 when h_cnt=0; frame_start = 1 when h_cnt=0 and v_cnt=0.
REQ-029 Outside RUN: de, line_start, frame_start = 0; hsync, vsync deasserted (level !SYNC_POL); x, y = 0; counters held at 0.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, clear the synchronizer, lock count and counters, and set outputs per REQ-029 with running=0.
REQ-031 rst_n deassertion SHALL be followed by the normal IDLE->WAIT_LOCK->RUN sequence; reset mid-frame truncates the frame with no further pulses.

Verification
Bench parameters: H = 8/2/3/3 (H_TOTAL 16); V = 4/1/2/1 (V_TOTAL 8); LOCK_WAIT 4; SYNC_POL 0.
REQ-032 Startup: enable=1, then pll_locked rises at cycle 0 -> running=1 at cycle 2+4 (sync+wait); first frame_start and de one clock later with x=0, y=0.
REQ-033 Line timing: in RUN -> de high for 8 clocks, x=0..7; hsync low for exactly 3 clocks, starting 10 clocks after line_start; period 16 clocks.
REQ-034 Frame timing: in RUN -> 4 lines with de, vsync low for 2 lines starting at line 5, frame_start every 128 clocks.
REQ-035 Lock glitch: pll_locked low for 1 clock during WAIT_LOCK -> the count restarts and RUN entry is delayed. The same glitch in RUN -> IDLE 3 clocks later, and outputs inactive the clock after that.
REQ-036 Async reset mid-line (h_cnt=5): rst_n low between clock edges -> outputs inactive immediately, without a clock edge; after release with lock held, frame_start again after 2+4+1 clocks.
REQ-037 enable low during vsync -> vsync deasserted one clock after IDLE entry; no frame_start while enable=0.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Free-running raster timing generator gated by a PLL lock qualifier.
//   The lock input is synchronized, and continuous lock is required for
//   LOCK_WAIT clocks before the horizontal/vertical counters start.
//   Every timing output is registered and lags the counters by one clock.
//
// Ports
//   clk          pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock, asynchronous to clk
//   enable       synchronous run request (low forces IDLE)
//   hsync/vsync  sync pulses, SYNC_POL level while asserted
//   de           data enable during active pixels
//   x, y         active pixel column / line (0 outside active video)
//   line_start   one-clock pulse at h_cnt = 0
//   frame_start  one-clock pulse at h_cnt = 0, v_cnt = 0
//   running      high while the FSM is in RUN
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LCW     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_DE_END = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SY_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_DE_END = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SY_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SY_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LCW-1:0] LC_LAST = LCW'(LOCK_WAIT - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  logic           sync1_q, lock_s_q;
  logic [1:0]     state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [10:0]    h_cnt_q, h_cnt_d;
  logic [9:0]     v_cnt_q, v_cnt_d;

  logic           hsync_d, vsync_d, de_d, line_start_d, frame_start_d, running_d;
  logic [10:0]    x_d;
  logic [9:0]     y_d;
  logic           run_now, lock_ok;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  assign lock_ok = enable && lock_s_q;
  assign run_now = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (lock_ok) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!lock_ok) begin
          state_d = ST_IDLE;
        end else if (lock_cnt_q == LC_LAST) begin
          state_d = ST_RUN;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters only advance while RUN persists; they read zero on the
  // first RUN cycle and are held at zero everywhere else.
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (run_now && (state_d == ST_RUN)) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // Output decode of the current counter values; registered below.
  always_comb begin
    de_d          = run_now && (h_cnt_q < H_DE_END) && (v_cnt_q < V_DE_END);
    hsync_d       = (run_now && (h_cnt_q >= H_SY_BEG) && (h_cnt_q < H_SY_END))
                    ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (run_now && (v_cnt_q >= V_SY_BEG) && (v_cnt_q < V_SY_END))
                    ? SYNC_POL : ~SYNC_POL;
    x_d           = de_d ? h_cnt_q : '0;
    y_d           = de_d ? v_cnt_q : '0;
    line_start_d  = run_now && (h_cnt_q == '0);
    frame_start_d = run_now && (h_cnt_q == '0) && (v_cnt_q == '0);
    running_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      running     <= running_d;
    end
  end

endmodule
